thresh_fifo: RTL and testbench

//  Synchronous FIFO, successor to the basic register FIFO. Adds: any depth (not only 2^n),

---
 rtl/thresh_fifo.sv | 133 +++++++++++++
 tb/tb_thresh_fifo.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/thresh_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : thresh_fifo
//  Description : Synchronous flop-based FIFO of arbitrary depth with show-ahead
//                read, runtime almost-full/almost-empty thresholds, sticky
//                overflow/underflow flags and push-while-full when a pop is
//                accepted in the same cycle.
//                Optional feature macro: FIFO_BYPASS_EN (push+pop while empty
//                passes dat_i straight through to dat_o).
//  Revision    : 1.0 - initial release
// ============================================================================
module thresh_fifo #(
  parameter int DATA_WIDTH   = 32,
  parameter int BUFFER_DEPTH = 6,
  parameter int PTR_WIDTH    = $clog2(BUFFER_DEPTH),
  parameter int CNT_WIDTH    = $clog2(BUFFER_DEPTH + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  flush_i,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] dat_i,
  output logic                  full_o,
  input  logic                  pop_i,
  output logic [DATA_WIDTH-1:0] dat_o,
  output logic                  empty_o,
  output logic [CNT_WIDTH-1:0]  cnt_o,
  input  logic [CNT_WIDTH-1:0]  afull_thr_i,
  input  logic [CNT_WIDTH-1:0]  aempty_thr_i,
  output logic                  afull_o,
  output logic                  aempty_o,
  input  logic                  err_clr_i,
  output logic                  ovf_o,
  output logic                  udf_o
);

  localparam logic [PTR_WIDTH-1:0] c_last_ptr = PTR_WIDTH'(BUFFER_DEPTH - 1);
  localparam logic [CNT_WIDTH-1:0] c_depth    = CNT_WIDTH'(BUFFER_DEPTH);

  logic [DATA_WIDTH-1:0] r_mem [BUFFER_DEPTH];
  logic [PTR_WIDTH-1:0]  r_rd_ptr;
  logic [PTR_WIDTH-1:0]  r_wr_ptr;
  logic [CNT_WIDTH-1:0]  r_cnt;
  logic                  r_ovf;
  logic                  r_udf;

  logic                  w_empty;
  logic                  w_full;
  logic                  w_bypass;
  logic                  w_pop_hs;
  logic                  w_push_hs;
  logic                  w_push_store;
  logic                  w_pop_take;
  logic [PTR_WIDTH-1:0]  w_rd_ptr_inc;
  logic [PTR_WIDTH-1:0]  w_wr_ptr_inc;
  logic [CNT_WIDTH-1:0]  w_cnt_nxt;

  assign w_empty = (r_cnt == '0);
  assign w_full  = (r_cnt == c_depth);

`ifdef FIFO_BYPASS_EN
  // Push and pop on an empty FIFO: the word flows through without touching storage.
  assign w_bypass = w_empty & push_i & pop_i;
  assign dat_o    = w_bypass ? dat_i : r_mem[r_rd_ptr];
`else
  assign w_bypass = 1'b0;
  assign dat_o    = r_mem[r_rd_ptr];
`endif

  // A pop frees a slot, so a push into a full FIFO is accepted alongside it.
  assign w_pop_hs     = pop_i & (~w_empty | w_bypass);
  assign w_push_hs    = push_i & (~w_full | w_pop_hs);
  assign w_push_store = w_push_hs & ~w_bypass;
  assign w_pop_take   = w_pop_hs & ~w_bypass;

  // Pointers wrap by explicit compare so non power-of-two depths work.
  assign w_rd_ptr_inc = (r_rd_ptr == c_last_ptr) ? '0 : r_rd_ptr + PTR_WIDTH'(1);
  assign w_wr_ptr_inc = (r_wr_ptr == c_last_ptr) ? '0 : r_wr_ptr + PTR_WIDTH'(1);

  // Occupancy only moves when exactly one side of the FIFO is active.
  always_comb begin
    w_cnt_nxt = r_cnt;
    if (w_push_store && !w_pop_take) begin
      w_cnt_nxt = r_cnt + CNT_WIDTH'(1);
    end else if (w_pop_take && !w_push_store) begin
      w_cnt_nxt = r_cnt - CNT_WIDTH'(1);
    end
  end

  // Control state: pointers, occupancy and sticky error flags.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_cnt    <= '0;
      r_ovf    <= 1'b0;
      r_udf    <= 1'b0;
    end else if (flush_i) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_cnt    <= '0;
      r_ovf    <= 1'b0;
      r_udf    <= 1'b0;
    end else begin
      if (w_push_store) r_wr_ptr <= w_wr_ptr_inc;
      if (w_pop_take)   r_rd_ptr <= w_rd_ptr_inc;
      r_cnt <= w_cnt_nxt;
      if (push_i && !w_push_hs) r_ovf <= 1'b1;
      else if (err_clr_i)       r_ovf <= 1'b0;
      if (pop_i && !w_pop_hs)   r_udf <= 1'b1;
      else if (err_clr_i)       r_udf <= 1'b0;
    end
  end

  // Storage: cleared on reset, preserved across flush.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < BUFFER_DEPTH; i++) r_mem[i] <= '0;
    end else if (!flush_i && w_push_store) begin
      r_mem[r_wr_ptr] <= dat_i;
    end
  end

  assign full_o   = w_full;
  assign empty_o  = w_empty;
  assign cnt_o    = r_cnt;
  assign afull_o  = (r_cnt >= afull_thr_i);
  assign aempty_o = (r_cnt <= aempty_thr_i);
  assign ovf_o    = r_ovf;
  assign udf_o    = r_udf;

endmodule
`default_nettype wire

// File: tb/tb_thresh_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : tb_thresh_fifo
//  Description : Self-checking bench for thresh_fifo (DEPTH=6, WIDTH=32).
//                Accepted pushes are queued as expected read data; each
//                accepted pop compares dat_o against the queue head.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_thresh_fifo;

  localparam int c_dw    = 32;
  localparam int c_depth = 6;
  localparam int c_cw    = 3;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            flush = 1'b0;
  logic            push = 1'b0;
  logic [c_dw-1:0] din = '0;
  logic            full;
  logic            pop = 1'b0;
  logic [c_dw-1:0] dout;
  logic            empty;
  logic [c_cw-1:0] cnt;
  logic [c_cw-1:0] afull_thr = '0;
  logic [c_cw-1:0] aempty_thr = '0;
  logic            afull;
  logic            aempty;
  logic            err_clr = 1'b0;
  logic            ovf;
  logic            udf;

  logic [c_dw-1:0] sb[$];
  logic            m_ovf = 1'b0;
  logic            m_udf = 1'b0;
  int              n_total = 0;
  int              n_bad = 0;

  thresh_fifo #(.DATA_WIDTH(c_dw), .BUFFER_DEPTH(c_depth)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .flush_i(flush),
    .push_i(push), .dat_i(din), .full_o(full),
    .pop_i(pop), .dat_o(dout), .empty_o(empty), .cnt_o(cnt),
    .afull_thr_i(afull_thr), .aempty_thr_i(aempty_thr),
    .afull_o(afull), .aempty_o(aempty),
    .err_clr_i(err_clr), .ovf_o(ovf), .udf_o(udf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_state();
    int m_cnt;
    m_cnt = sb.size();
    check("cnt", 64'(cnt), 64'(m_cnt));
    check("full", 64'(full), 64'(m_cnt == c_depth));
    check("empty", 64'(empty), 64'(m_cnt == 0));
    check("ovf", 64'(ovf), 64'(m_ovf));
    check("udf", 64'(udf), 64'(m_udf));
    check("afull", 64'(afull), 64'(m_cnt >= int'(afull_thr)));
    check("aempty", 64'(aempty), 64'(m_cnt <= int'(aempty_thr)));
    if (m_cnt != 0) check("head", 64'(dout), 64'(sb[0]));
  endtask

  // One clock cycle of stimulus with the model updated in step.
  task automatic step(input logic p, input logic [c_dw-1:0] d, input logic q,
                      input logic fl, input logic ec);
    int              m_cnt;
    logic            pop_hs;
    logic            push_hs;
    logic            byp;
    logic [c_dw-1:0] exp_d;
    @(negedge clk);
    push = p; din = d; pop = q; flush = fl; err_clr = ec;
    #1;
    m_cnt = sb.size();
    byp = 1'b0;
`ifdef FIFO_BYPASS_EN
    byp = (m_cnt == 0) && p && q;
`endif
    pop_hs  = q && (m_cnt != 0 || byp);
    push_hs = p && (m_cnt != c_depth || pop_hs);
    if (fl) begin
      sb.delete();
      m_ovf = 1'b0;
      m_udf = 1'b0;
    end else begin
      if (byp) begin
        check("bypass_dat", 64'(dout), 64'(d));
      end else begin
        if (pop_hs) begin
          exp_d = sb.pop_front();
          check("pop_dat", 64'(dout), 64'(exp_d));
        end
        if (push_hs) sb.push_back(d);
      end
      if (p && !push_hs) m_ovf = 1'b1;
      else if (ec)       m_ovf = 1'b0;
      if (q && !pop_hs)  m_udf = 1'b1;
      else if (ec)       m_udf = 1'b0;
    end
    @(posedge clk);
    #1;
    push = 1'b0; pop = 1'b0; flush = 1'b0; err_clr = 1'b0;
    check_state();
  endtask

  // Reset with a push in flight to show reset beats everything.
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; push = 1'b1; din = 32'hDEAD_BEEF;
    @(posedge clk);
    #1;
    rst_n = 1'b1; push = 1'b0;
    sb.delete();
    m_ovf = 1'b0;
    m_udf = 1'b0;
    check_state();
    check("rst_dat", 64'(dout), 64'h0);
  endtask

  initial begin
    int c;
    logic [c_dw-1:0] v;

    // Reset with afull threshold 0: afull must be high on an empty FIFO.
    afull_thr = 3'd0; aempty_thr = 3'd1;
    do_reset();
    check("rst_afull_thr0", 64'(afull), 64'h1);
    check("rst_aempty", 64'(aempty), 64'h1);

    // Threshold walk doubles as the fill: push A0..A5.
    afull_thr = 3'd4; aempty_thr = 3'd1;
    step(1'b0, '0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) step(1'b1, 32'hA0 + 32'(i), 1'b0, 1'b0, 1'b0);
    check("fill_full", 64'(full), 64'h1);
    check("fill_cnt", 64'(cnt), 64'd6);
    for (int i = 0; i < 6; i++) step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    check("drain_empty", 64'(empty), 64'h1);

    // Mixed traffic with occupancy held in 2..5 so pointers wrap.
    for (int i = 0; i < 3; i++) step(1'b1, 32'h100 + 32'(i), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      c = sb.size();
      v = 32'h200 + 32'(i);
      if (c <= 2)      step(1'b1, v, 1'b0, 1'b0, 1'b0);
      else if (c >= 5) step(1'b0, v, 1'b1, 1'b0, 1'b0);
      else begin
        case ($urandom_range(0, 2))
          0:       step(1'b1, v, 1'b0, 1'b0, 1'b0);
          1:       step(1'b0, v, 1'b1, 1'b0, 1'b0);
          default: step(1'b1, v, 1'b1, 1'b0, 1'b0);
        endcase
      end
    end

    // Fill to full, then push 0xBB with a simultaneous pop.
    while (sb.size() < c_depth) step(1'b1, 32'h300 + 32'(sb.size()), 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'hBB, 1'b1, 1'b0, 1'b0);
    check("pp_full_cnt", 64'(cnt), 64'd6);
    check("pp_full_ovf", 64'(ovf), 64'h0);

    // Overflow: sticky, cleared by err_clr, set wins over clear.
    step(1'b1, 32'hCC, 1'b0, 1'b0, 1'b0);
    check("ovf_set", 64'(ovf), 64'h1);
    step(1'b0, '0, 1'b0, 1'b0, 1'b0);
    check("ovf_hold", 64'(ovf), 64'h1);
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    check("ovf_clr", 64'(ovf), 64'h0);
    step(1'b1, 32'hCD, 1'b0, 1'b0, 1'b1);
    check("ovf_set_wins", 64'(ovf), 64'h1);

    // Drain: 0xBB must come out last.
    while (sb.size() > 1) step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    check("bb_last", 64'(dout), 64'hBB);
    step(1'b0, '0, 1'b1, 1'b0, 1'b1);

    // Push and pop while empty.
    step(1'b1, 32'h55, 1'b1, 1'b0, 1'b0);
`ifdef FIFO_BYPASS_EN
    check("byp_cnt", 64'(cnt), 64'd0);
    check("byp_udf", 64'(udf), 64'h0);
`else
    check("nobyp_cnt", 64'(cnt), 64'd1);
    check("nobyp_udf", 64'(udf), 64'h1);
`endif

    // Underflow plus flush with push at cnt=3.
    while (sb.size() != 0) step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    check("udf_set", 64'(udf), 64'h1);
    for (int i = 0; i < 3; i++) step(1'b1, 32'h400 + 32'(i), 1'b0, 1'b0, 1'b0);
    check("pre_flush_cnt", 64'(cnt), 64'd3);
    step(1'b1, 32'h4FF, 1'b0, 1'b1, 1'b0);
    check("flush_cnt", 64'(cnt), 64'd0);
    check("flush_empty", 64'(empty), 64'h1);
    check("flush_udf", 64'(udf), 64'h0);

    // Mid-stream reset.
    for (int i = 0; i < 4; i++) step(1'b1, 32'h500 + 32'(i), 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h5AA, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h5AB, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h5AC, 1'b0, 1'b0, 1'b0);
    do_reset();
    for (int i = 0; i < 2; i++) step(1'b1, 32'h600 + 32'(i), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) step(1'b0, '0, 1'b1, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
